// File: rtl/alsu_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : alsu_cmd_seq
// Description : Command FIFO and issue sequencer that feeds registered
//               operand/control words to an ALSU, repeating each command
//               in_repeat+1 consecutive cycles. Define ALSU_CMD_CHECK_EN to
//               drop illegal commands and count them in drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module alsu_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_A,
    input  logic [5:0]               in_B,
    input  logic [2:0]               in_opcode,
    input  logic                     in_cin,
    input  logic                     in_serial_in,
    input  logic                     in_red_op_A,
    input  logic                     in_red_op_B,
    input  logic                     in_bypass_A,
    input  logic                     in_bypass_B,
    input  logic                     in_direction,
    input  logic [REP_W-1:0]         in_repeat,
    output logic [5:0]               A,
    output logic [5:0]               B,
    output logic [2:0]               opcode,
    output logic                     cin,
    output logic                     serial_in,
    output logic                     red_op_A,
    output logic                     red_op_B,
    output logic                     bypass_A,
    output logic                     bypass_B,
    output logic                     direction,
    output logic                     issue_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_CMD_W = 22 + REP_W;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ISSUE = 1'b1;

    logic [c_CMD_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [0:0]         r_state;
    logic [REP_W-1:0]   r_rep_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [c_CMD_W-1:0] w_wr_cmd;
    logic [c_CMD_W-1:0] w_head;

    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign count    = r_count;
    assign busy     = (r_state == c_ISSUE);
    assign w_accept = in_valid && in_ready;

    assign w_wr_cmd = {in_A, in_B, in_opcode, in_cin, in_serial_in, in_red_op_A,
                       in_red_op_B, in_bypass_A, in_bypass_B, in_direction, in_repeat};
    assign w_head   = r_mem[r_rd_ptr];

    // A new head is taken whenever the current command has no repeats left.
    assign w_pop = !w_empty && (r_rep_cnt == '0);

`ifdef ALSU_CMD_CHECK_EN
    logic       w_bad;
    logic [7:0] r_drop_cnt;

    // Opcodes 6/7 are invalid; reductions only make sense for AND/XOR.
    assign w_bad  = (in_opcode[2:1] == 2'b11) ||
                    ((in_red_op_A || in_red_op_B) && (in_opcode[2:1] != 2'b00));
    assign w_push = w_accept && !w_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_accept && w_bad && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign w_push   = w_accept;
    assign drop_cnt = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_wr_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_rep_cnt   <= '0;
            issue_valid <= 1'b0;
            {A, B, opcode, cin, serial_in, red_op_A, red_op_B,
             bypass_A, bypass_B, direction} <= '0;
        end else begin
            case (r_state)
                c_ISSUE: begin
                    if (r_rep_cnt != '0) begin
                        r_rep_cnt <= r_rep_cnt - REP_W'(1);
                    end else if (w_pop) begin
                        {A, B, opcode, cin, serial_in, red_op_A, red_op_B,
                         bypass_A, bypass_B, direction, r_rep_cnt} <= w_head;
                    end else begin
                        r_state     <= c_IDLE;
                        issue_valid <= 1'b0;
                        {A, B, opcode, cin, serial_in, red_op_A, red_op_B,
                         bypass_A, bypass_B, direction} <= '0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_state     <= c_ISSUE;
                        issue_valid <= 1'b1;
                        {A, B, opcode, cin, serial_in, red_op_A, red_op_B,
                         bypass_A, bypass_B, direction, r_rep_cnt} <= w_head;
                    end else begin
                        r_state     <= c_IDLE;
                        issue_valid <= 1'b0;
                        {A, B, opcode, cin, serial_in, red_op_A, red_op_B,
                         bypass_A, bypass_B, direction} <= '0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
